// File: rtl/mips_pkg.sv
// Shared datapath types for the multiply/divide unit: op codes, FSM states and op classifiers.
package mips_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_t;

   typedef enum logic [1:0] {
      MD_IDLE,
      MD_RUN,
      MD_FIX,
      MD_DONE
   } md_state_t;

   function automatic logic md_is_arith(input md_op_t op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic md_is_div(input md_op_t op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic md_is_signed(input md_op_t op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/md_datapath.sv
// Iterative shift-add multiplier / restoring divider on unsigned magnitudes.
// hi_o/lo_o: product halves, or remainder/quotient for divides.
module md_datapath
   import mips_pkg::*;
#(
   parameter int unsigned N = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load_i,
   input  logic         step_i,
   input  logic         div_i,
   input  logic [N-1:0] opa_i,
   input  logic [N-1:0] opb_i,
   output logic [N-1:0] hi_o,
   output logic [N-1:0] lo_o
);

   logic [2*N-1:0] acc_q, acc_d;
   logic [N-1:0]   b_q, b_d;
   logic           div_q, div_d;
   logic [N:0]     sum;
   logic [N:0]     shifted;
   logic [N:0]     trial;

   always_comb begin
      acc_d   = acc_q;
      b_d     = b_q;
      div_d   = div_q;
      sum     = '0;
      shifted = '0;
      trial   = '0;
      if (load_i) begin
         div_d = div_i;
         acc_d = '0;
         if (div_i) begin
            acc_d[N-1:0] = opa_i;
            b_d          = opb_i;
         end else begin
            acc_d[N-1:0] = opb_i;
            b_d          = opa_i;
         end
      end else if (step_i) begin
         if (div_q) begin
            // Remainder lives in the upper half; dividend bits shift out of the lower half as quotient bits shift in.
            shifted = {acc_q[2*N-1:N], acc_q[N-1]};
            trial   = shifted - {1'b0, b_q};
            if (!trial[N]) begin
               acc_d = {trial[N-1:0], acc_q[N-2:0], 1'b1};
            end else begin
               acc_d = {shifted[N-1:0], acc_q[N-2:0], 1'b0};
            end
         end else begin
            // {sum, lo} is the 2N+1-bit accumulator; the carry lands in the top bit before the right shift.
            sum   = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, b_q} : '0);
            acc_d = {sum, acc_q[N-1:1]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         acc_q <= '0;
         b_q   <= '0;
         div_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         b_q   <= b_d;
         div_q <= div_d;
      end
   end

   assign hi_o = acc_q[2*N-1:N];
   assign lo_o = acc_q[N-1:0];

endmodule

// File: rtl/mul_div_unit.sv
// Multiply/divide unit with HI/LO registers: FSM, iteration counter, sign handling and result write-back.
module mul_div_unit
   import mips_pkg::*;
#(
   parameter int unsigned N = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [2:0]   op,
   input  logic [N-1:0] src1,
   input  logic [N-1:0] src2,
   output logic         busy,
   output logic         done,
   output logic         div_by_zero,
   output logic [N-1:0] hi,
   output logic [N-1:0] lo
);

   localparam int unsigned CW = $clog2(N);

   md_state_t      state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           is_div_q, is_div_d;
   logic           neg_q, neg_d;
   logic           neg_rem_q, neg_rem_d;
   logic           dbz_q, dbz_d;
   logic [N-1:0]   hi_q, hi_d;
   logic [N-1:0]   lo_q, lo_d;

   md_op_t         op_in;
   logic           signed_op;
   logic           dp_load, dp_step;
   logic [N-1:0]   mag_a, mag_b;
   logic [N-1:0]   dp_hi, dp_lo;
   logic [2*N-1:0] prod;

   assign op_in = md_op_t'(op);

   md_datapath #(.N(N)) u_dp (
      .clk     (clk),
      .reset_n (reset_n),
      .load_i  (dp_load),
      .step_i  (dp_step),
      .div_i   (md_is_div(op_in)),
      .opa_i   (mag_a),
      .opb_i   (mag_b),
      .hi_o    (dp_hi),
      .lo_o    (dp_lo)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      dbz_d     = dbz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      dp_load   = 1'b0;
      dp_step   = 1'b0;
      signed_op = md_is_signed(op_in);
      mag_a     = (signed_op && src1[N-1]) ? -src1 : src1;
      mag_b     = (signed_op && src2[N-1]) ? -src2 : src2;
      prod      = neg_q ? -{dp_hi, dp_lo} : {dp_hi, dp_lo};

      unique case (state_q)
         MD_IDLE: begin
            if (start) begin
               if (md_is_arith(op_in)) begin
                  state_d   = MD_RUN;
                  cnt_d     = CW'(N - 1);
                  dp_load   = 1'b1;
                  is_div_d  = md_is_div(op_in);
                  neg_d     = signed_op & (src1[N-1] ^ src2[N-1]);
                  neg_rem_d = signed_op & src1[N-1];
                  dbz_d     = md_is_div(op_in) && (src2 == '0);
               end else if (op_in == MD_MTHI) begin
                  hi_d = src1;
               end else if (op_in == MD_MTLO) begin
                  lo_d = src1;
               end
            end
         end
         MD_RUN: begin
            dp_step = 1'b1;
            if (cnt_q == '0) begin
               state_d = MD_FIX;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         MD_FIX: begin
            state_d = MD_DONE;
            if (is_div_q) begin
               // With a zero divisor the remainder equals |src1|, so the dividend-sign fix-up restores src1 raw.
               lo_d = dbz_q ? '1 : (neg_q ? -dp_lo : dp_lo);
               hi_d = neg_rem_q ? -dp_hi : dp_hi;
            end else begin
               {hi_d, lo_d} = prod;
            end
         end
         MD_DONE: begin
            state_d = MD_IDLE;
         end
         default: begin
            state_d = MD_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= MD_IDLE;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         dbz_q     <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         dbz_q     <= dbz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy        = (state_q != MD_IDLE);
   assign done        = (state_q == MD_DONE);
   assign div_by_zero = (state_q == MD_DONE) && dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule
